// File: rtl/count_ctrl.sv
// Debounced push-button up/down counter with parallel load and wrap pulse.
// The output value feeds the 4-digit BCD/7-segment display stage.

module count_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             db;
  logic             db_d;

  // Released is the idle level for every stage of the chain.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

  // Any sample agreeing with the accepted state restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db   <= 1'b1;
      db_d <= 1'b1;
    end else begin
      db_d <= db;
      if (sync_2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync_2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Press is the 1->0 transition of the debounced level; release is silent.
  assign press = db_d & ~db;

endmodule

module count_ctrl #(
  parameter int WIDTH           = 10,
  parameter int MAX_COUNT       = 999,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_down_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  logic             up_press;
  logic             down_press;
  op_e              op;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  count_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_up (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_up_n),
    .press(up_press)
  );

  count_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_down (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_down_n),
    .press(down_press)
  );

  // Load beats enable, which beats the button events; simultaneous
  // up and down cancel out.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (enable && up_press && !down_press) begin
      op = OP_UP;
    end else if (enable && down_press && !up_press) begin
      op = OP_DOWN;
    end
  end

  always_comb begin
    count_nxt = count_out;
    wrap_nxt  = 1'b0;
    case (op)
      OP_LOAD: count_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      OP_UP: begin
        if (count_out == MAX_VAL) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_out + 1'b1;
        end
      end
      OP_DOWN: begin
        if (count_out == '0) begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_out - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
      wrap      <= 1'b0;
    end else begin
      count_out <= count_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: stimulus queues expected output changes,
// a negedge monitor pops and compares them whenever count_out/wrap change.

module tb_count_ctrl;

  localparam int D   = 4;
  localparam int LAT = D + 3;  // drive-to-observe cycles for a clean press

  typedef struct {
    int count;
    int wrap;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       load;
  logic [9:0] load_value;
  logic       enable;
  logic [9:0] count_out;
  logic       wrap;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic [10:0] prev;
  exp_t sb[$];

  count_ctrl #(
    .WIDTH          (10),
    .MAX_COUNT      (999),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up_n  (btn_up_n),
    .btn_down_n(btn_down_n),
    .load      (load),
    .load_value(load_value),
    .enable    (enable),
    .count_out (count_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int c, input int w, input int at);
    exp_t e;
    e.count = c;
    e.wrap  = w;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic do_load(input int v, input int expv);
    load_value = 10'(v);
    load       = 1'b1;
    expect_ev(expv, 0, cyc + 1);
    tick();
    load = 1'b0;
    tick(3);
  endtask

  task automatic press(input bit up, input int hold);
    if (up) btn_up_n = 1'b0;
    else    btn_down_n = 1'b0;
    tick(hold);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    tick(12);
  endtask

  always @(negedge clk) begin : monitor
    logic [10:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {count_out, wrap};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change: got count=%0d wrap=%0d expected no change (cycle %0d)",
                   count_out, wrap, cyc);
        end else begin
          e = sb.pop_front();
          check("ev_count", 32'(count_out), e.count);
          check("ev_wrap",  32'(wrap),      e.wrap);
          check("ev_cycle", cyc,            e.cyc);
        end
        prev = cur;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    load       = 1'b0;
    load_value = '0;
    enable     = 1'b1;
    tick(2);
    check("reset_count", 32'(count_out), 0);
    check("reset_wrap",  32'(wrap),      0);
    rst_n = 1'b1;
    tick(2);
    prev   = {count_out, wrap};
    mon_en = 1'b1;

    // 1: held press gives a single increment at the fixed latency
    btn_up_n = 1'b0;
    expect_ev(1, 0, cyc + LAT);
    tick(20);
    btn_up_n = 1'b1;
    tick(12);
    check("t1_held_once", 32'(count_out), 1);

    // 2: 3-cycle glitches never reach the debounce threshold
    for (int i = 0; i < 30; i++) begin
      btn_up_n = (i % 4 == 3);
      tick();
    end
    btn_up_n = 1'b1;
    tick(12);
    check("t2_glitch", 32'(count_out), 1);

    // 3: wrap in both directions
    do_load(999, 999);
    expect_ev(0, 1, cyc + LAT);
    expect_ev(0, 0, cyc + LAT + 1);
    press(1'b1, 10);
    expect_ev(999, 1, cyc + LAT);
    expect_ev(999, 0, cyc + LAT + 1);
    press(1'b0, 10);

    // 4: load clamps above MAX_COUNT, no wrap on load
    do_load(5, 5);
    do_load(1023, 999);
    check("t4_wrap", 32'(wrap), 0);
    expect_ev(998, 0, cyc + LAT);
    press(1'b0, 10);
    expect_ev(999, 0, cyc + LAT);
    press(1'b1, 10);

    // 5: simultaneous presses cancel; disabled press is dropped, no repeat
    btn_up_n   = 1'b0;
    btn_down_n = 1'b0;
    tick(12);
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    tick(12);
    check("t5_both", 32'(count_out), 999);
    enable   = 1'b0;
    btn_up_n = 1'b0;
    tick(12);
    enable = 1'b1;
    tick(10);
    btn_up_n = 1'b1;
    tick(12);
    check("t5_disabled", 32'(count_out), 999);

    // load held across the press event swallows it
    btn_up_n   = 1'b0;
    load_value = 10'd200;
    load       = 1'b1;
    expect_ev(200, 0, cyc + 1);
    tick(10);
    load = 1'b0;
    tick(5);
    btn_up_n = 1'b1;
    tick(12);
    check("t5_load_wins", 32'(count_out), 200);

    // 6: async reset mid-debounce, button held through release
    do_load(37, 37);
    btn_up_n = 1'b0;
    tick(4);
    expect_ev(0, 0, cyc);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 32'(count_out), 0);
    tick(2);
    rst_n = 1'b1;
    expect_ev(1, 0, cyc + LAT);
    tick(12);
    btn_up_n = 1'b1;
    tick(12);
    check("t6_after_reset", 32'(count_out), 1);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
